uart_rx_hex_display: RTL and testbench

//  UART receiver driving a NUM_DIGITS-digit hex 7-segment display. Sits between the board

---
 rtl/uart_rx_hex_display.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_rx_hex_display.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_hex_display.sv
// uart_rx_hex_display
//   8N1 UART receiver that feeds a NUM_DIGITS-digit hex 7-segment display.
//   Raw mode shifts each received byte in as two digits. ASCII mode
//   (ASCII_MODE=1) shifts in one digit per typed hex character, and CR
//   blanks the display to zero. A stop bit sampled low sets a sticky
//   framing-error flag and the byte is discarded.
// Ports
//   i_Clk        system clock
//   i_Rst_L      async active-low reset (release is synchronised internally)
//   i_UART_RX    serial input, idle high, LSB first
//   i_Clear      sync pulse: zero the display, clear o_Frame_Err
//   o_RX_DV      1-cycle strobe, o_RX_Byte holds a new good byte
//   o_RX_Byte    last good byte
//   o_Frame_Err  sticky framing-error flag
//   o_Segments   digit k at [7k+6:7k] = {A..G}, digit 0 rightmost
module uart_rx_hex_display #(
    parameter int CLKS_PER_BIT   = 217,
    parameter int NUM_DIGITS     = 2,
    parameter int ASCII_MODE     = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_UART_RX,
    input  logic                    i_Clear,
    output logic                    o_RX_DV,
    output logic [7:0]              o_RX_Byte,
    output logic                    o_Frame_Err,
    output logic [7*NUM_DIGITS-1:0] o_Segments
);

    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int SEG_W  = 7 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_e;

    // Reset synchroniser: asserts immediately, releases on a clock edge.
    logic rst_meta_q, rst_n_q;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // RX synchroniser, reset to the idle level so reset never looks like a start bit.
    logic rx_meta_q, rx_sync_q;
    always_ff @(posedge i_Clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_UART_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             dv_q, dv_d;
    logic [7:0]       byte_q, byte_d;
    logic             err_q, err_d;
    logic             err_set;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic [SEG_W-1:0]  seg_q, seg_d;

    // FSM state register
    always_ff @(posedge i_Clk or negedge rst_n_q) begin
        if (!rst_n_q) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_sync_q) state_d = START;
            START:   if (cnt_q == HALF_LAST) state_d = rx_sync_q ? IDLE : DATA;
            DATA:    if (cnt_q == BIT_LAST && idx_q == 3'd7) state_d = STOP;
            STOP:    if (cnt_q == BIT_LAST) state_d = CLEANUP;
            CLEANUP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs / datapath next values
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dv_d    = 1'b0;
        byte_d  = byte_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync_q;
                    idx_d          = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        dv_d   = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        err_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Frame error set takes priority over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (err_set)      err_d = 1'b1;
        else if (i_Clear) err_d = 1'b0;
    end

    // {valid, nibble} for an ASCII hex character
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        logic [7:0] t;
        t = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            t = c - 8'h30;
            return {1'b1, t[3:0]};
        end
        if (c >= 8'h41 && c <= 8'h46) begin
            t = c - 8'h37;
            return {1'b1, t[3:0]};
        end
        if (c >= 8'h61 && c <= 8'h66) begin
            t = c - 8'h57;
            return {1'b1, t[3:0]};
        end
        return 5'b0_0000;
    endfunction

    // Display register: updated on the DV cycle, clear wins.
    logic [4:0] hv;
    always_comb begin
        disp_d = disp_q;
        hv     = hex_val(byte_q);
        if (dv_q) begin
            if (ASCII_MODE == 0) begin
                disp_d = (disp_q << 8) | DISP_W'(byte_q);
            end else if (hv[4]) begin
                disp_d = (disp_q << 4) | DISP_W'(hv[3:0]);
            end else if (byte_q == 8'h0D) begin
                disp_d = '0;
            end
        end
        if (i_Clear) disp_d = '0;
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;
            4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;
            4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;
            4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;
            4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    always_comb begin
        seg_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_d[7*k +: 7] = (SEG_ACTIVE_LOW != 0) ? ~glyph(disp_q[4*k +: 4])
                                                    :  glyph(disp_q[4*k +: 4]);
        end
    end

    // Datapath registers
    always_ff @(posedge i_Clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
            err_q   <= 1'b0;
            disp_q  <= '0;
            seg_q   <= (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
        end
    end

    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_Frame_Err = err_q;
    assign o_Segments  = seg_q;

endmodule

// File: tb/tb_uart_rx_hex_display.sv
module tb_uart_rx_hex_display;

    localparam int CPB = 8;
    localparam int ND  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clear, rx_raw, rx_asc;
    logic dv_r, dv_a, err_r, err_a;
    logic [7:0] byte_r, byte_a;
    logic [7*ND-1:0] seg_r, seg_a;

    uart_rx_hex_display #(.CLKS_PER_BIT(CPB), .NUM_DIGITS(ND), .ASCII_MODE(0), .SEG_ACTIVE_LOW(1)) u_raw (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_UART_RX(rx_raw), .i_Clear(clear),
        .o_RX_DV(dv_r), .o_RX_Byte(byte_r), .o_Frame_Err(err_r), .o_Segments(seg_r));

    uart_rx_hex_display #(.CLKS_PER_BIT(CPB), .NUM_DIGITS(ND), .ASCII_MODE(1), .SEG_ACTIVE_LOW(1)) u_asc (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_UART_RX(rx_asc), .i_Clear(clear),
        .o_RX_DV(dv_a), .o_RX_Byte(byte_a), .o_Frame_Err(err_a), .o_Segments(seg_a));

    typedef struct {
        logic [7:0]  data;
        logic [15:0] disp;
    } vec_t;

    logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic [7:0] q_raw [$];
    logic [7:0] q_asc [$];
    int n_chk = 0, n_pass = 0;
    int n_dv_r = 0, n_dv_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Expected active-low segment word for a 4-digit hex value
    function automatic logic [27:0] seg_of(input logic [15:0] d);
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) r[7*k +: 7] = ~glyph_tab[d[4*k +: 4]];
        return r;
    endfunction

    // Drives one 8N1 frame, aligned to negedges; a good stop bit queues the byte.
    task automatic send(input bit asc, input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (stop) begin
            if (asc) q_asc.push_back(b);
            else     q_raw.push_back(b);
        end
        for (int i = 0; i < 10; i++) begin
            if (asc) rx_asc = f[i];
            else     rx_raw = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (asc) rx_asc = 1'b1;
        else     rx_raw = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard: every DV pops the oldest expected byte.
    always @(negedge clk) begin
        if (dv_r) begin
            n_dv_r++;
            if (q_raw.size() == 0) check("raw_unexpected_dv", {24'h0, byte_r}, 32'h100);
            else                   check("raw_dv_byte", {24'h0, byte_r}, {24'h0, q_raw.pop_front()});
        end
        if (dv_a) begin
            n_dv_a++;
            if (q_asc.size() == 0) check("asc_unexpected_dv", {24'h0, byte_a}, 32'h100);
            else                   check("asc_dv_byte", {24'h0, byte_a}, {24'h0, q_asc.pop_front()});
        end
    end

    vec_t raw_v [2];
    vec_t asc_v [5];
    int dv_before;

    initial begin
        raw_v[0] = '{8'h3C, 16'h003C};
        raw_v[1] = '{8'hA5, 16'h3CA5};
        asc_v[0] = '{8'h31, 16'h0001};   // '1'
        asc_v[1] = '{8'h66, 16'h001F};   // 'f'
        asc_v[2] = '{8'h5A, 16'h001F};   // 'Z' ignored
        asc_v[3] = '{8'h39, 16'h01F9};   // '9'
        asc_v[4] = '{8'h0D, 16'h0000};   // CR

        rst_n = 1'b0; clear = 1'b0; rx_raw = 1'b1; rx_asc = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_seg_off", {4'h0, seg_r}, {4'h0, 28'hFFF_FFFF});
        check("reset_dv", {31'h0, dv_r}, 32'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_seg_0000", {4'h0, seg_r}, {4'h0, seg_of(16'h0000)});
        check("idle_err", {31'h0, err_r}, 32'h0);
        check("idle_byte", {24'h0, byte_r}, 32'h0);
        check("idle_asc_seg", {4'h0, seg_a}, {4'h0, seg_of(16'h0000)});

        // Raw byte shift
        foreach (raw_v[i]) begin
            send(1'b0, raw_v[i].data, 1'b1);
            check("raw_seg", {4'h0, seg_r}, {4'h0, seg_of(raw_v[i].disp)});
        end
        check("raw_byte_hold", {24'h0, byte_r}, 32'hA5);

        // ASCII parse
        foreach (asc_v[i]) begin
            send(1'b1, asc_v[i].data, 1'b1);
            check("asc_seg", {4'h0, seg_a}, {4'h0, seg_of(asc_v[i].disp)});
        end
        check("asc_dv_count", n_dv_a, 5);

        // Framing error: byte discarded, display held, then cleared
        dv_before = n_dv_r;
        send(1'b0, 8'h55, 1'b0);
        check("ferr_set", {31'h0, err_r}, 32'h1);
        check("ferr_no_dv", n_dv_r, dv_before);
        check("ferr_seg_hold", {4'h0, seg_r}, {4'h0, seg_of(16'h3CA5)});
        check("ferr_byte_hold", {24'h0, byte_r}, 32'hA5);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("clear_err", {31'h0, err_r}, 32'h0);
        @(negedge clk);
        check("clear_seg", {4'h0, seg_r}, {4'h0, seg_of(16'h0000)});

        // Short low glitch rejected, then a clean frame
        dv_before = n_dv_r;
        rx_raw = 1'b0;
        repeat (2) @(negedge clk);
        rx_raw = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_dv", n_dv_r, dv_before);
        check("glitch_no_err", {31'h0, err_r}, 32'h0);
        send(1'b0, 8'h81, 1'b1);
        check("post_glitch_seg", {4'h0, seg_r}, {4'h0, seg_of(16'h0081)});

        // Reset mid-frame of 0xFF, then 0x12
        dv_before = n_dv_r;
        rx_raw = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_raw = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8 * CPB) @(negedge clk);
        check("midrst_no_dv", n_dv_r, dv_before);
        check("midrst_byte", {24'h0, byte_r}, 32'h0);
        send(1'b0, 8'h12, 1'b1);
        check("midrst_seg", {4'h0, seg_r}, {4'h0, seg_of(16'h0012)});
        check("midrst_dv_count", n_dv_r, dv_before + 1);
        check("midrst_err", {31'h0, err_r}, 32'h0);

        repeat (4) @(negedge clk);
        check("raw_queue_empty", q_raw.size(), 0);
        check("asc_queue_empty", q_asc.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
